// File: rtl/matrix_loader_pkg.sv
// Shared definitions for the 3x3 operand-pair loader.
//   N_ELEM       elements per 3x3 matrix
//   FRAME_BEATS  input beats per operand pair (A then B)
//   BEAT_W       width of the beat counter / bank write index
//   bank_state_t per-bank occupancy state
package matrix_loader_pkg;

  localparam int N_ELEM      = 9;
  localparam int FRAME_BEATS = 2 * N_ELEM;
  localparam int BEAT_W      = $clog2(FRAME_BEATS);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

endpackage

// File: rtl/matrix_bank.sv
// One storage bank holding an A/B operand pair (18 elements).
// Elements 0..8 are A, elements 9..17 are B, both row-major.
// Ports:
//   clk, rst_n  clock, async active-low reset (clears storage)
//   wr_en       write wr_data into element wr_idx this cycle
//   wr_idx      element index 0..17
//   wr_data     element value, stored bit-exact
//   rd_a, rd_b  packed read port of the A and B halves
module matrix_bank
  import matrix_loader_pkg::*;
#(
  parameter int W = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [BEAT_W-1:0]            wr_idx,
  input  logic [W-1:0]                 wr_data,
  output logic [0:N_ELEM-1][W-1:0]     rd_a,
  output logic [0:N_ELEM-1][W-1:0]     rd_b
);

  logic [W-1:0] mem [FRAME_BEATS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FRAME_BEATS; i++) mem[i] <= '0;
    end else if (wr_en && (wr_idx < BEAT_W'(FRAME_BEATS))) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    for (int i = 0; i < N_ELEM; i++) begin
      rd_a[i] = mem[i];
      rd_b[i] = mem[i + N_ELEM];
    end
  end

endmodule

// File: rtl/matrix_loader.sv
// Streams 18 elements per frame (A[0..8] then B[0..8]) into a pair of
// ping-pong banks and presents each complete operand pair to a 3x3
// multiplier stage with a valid/ready handshake.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_data/in_valid/in_ready   element stream input
//   flush                drop the partially loaded frame
//   A, B                 operand pair from the read bank, index = 3*row+col
//   out_valid/out_ready  operand-pair handshake
//   pair_count           wrapping count of consumed pairs
//
// Bank state table:
//   state   | meaning
//   EMPTY   | no data, waiting for first beat
//   FILLING | some beats of the frame written
//   FULL    | complete pair, waiting for the consumer
module matrix_loader
  import matrix_loader_pkg::*;
#(
  parameter int W = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [W-1:0]             in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [0:N_ELEM-1][W-1:0] A,
  output logic [0:N_ELEM-1][W-1:0] B,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               pair_count
);

  bank_state_t state_q [2];
  bank_state_t state_d [2];
  logic              wr_bank, rd_bank;
  logic [BEAT_W-1:0] beat_cnt;
  logic              accept, last_beat, handshake;
  logic [1:0]        wr_sel, rd_sel, bank_we;
  logic [0:N_ELEM-1][W-1:0] a0, b0, a1, b1;

  assign wr_sel = {wr_bank, ~wr_bank};
  assign rd_sel = {rd_bank, ~rd_bank};

  assign in_ready  = (state_q[wr_bank] != FULL);
  assign out_valid = (state_q[rd_bank] == FULL);

  // flush wins over a simultaneous beat: the element is dropped
  assign accept    = in_valid && in_ready && !flush;
  assign last_beat = accept && (beat_cnt == BEAT_W'(FRAME_BEATS - 1));
  assign handshake = out_valid && out_ready;
  assign bank_we   = accept ? wr_sel : 2'b00;

  // The read bank is FULL on a handshake and the write bank is never FULL
  // while accepting, so the two updates never target the same bank.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      if (handshake && rd_sel[i]) begin
        state_d[i] = EMPTY;
      end else if (accept && wr_sel[i]) begin
        state_d[i] = last_beat ? FULL : FILLING;
      end else if (flush && wr_sel[i] && (state_q[i] == FILLING)) begin
        state_d[i] = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q[0] <= EMPTY;
      state_q[1] <= EMPTY;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      beat_cnt   <= '0;
      pair_count <= 8'd0;
    end else begin
      if (flush) begin
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      end
      if (last_beat) wr_bank <= ~wr_bank;
      if (handshake) begin
        rd_bank    <= ~rd_bank;
        pair_count <= pair_count + 8'd1;
      end
    end
  end

  matrix_bank #(.W(W)) u_bank0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (bank_we[0]),
    .wr_idx  (beat_cnt),
    .wr_data (in_data),
    .rd_a    (a0),
    .rd_b    (b0)
  );

  matrix_bank #(.W(W)) u_bank1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (bank_we[1]),
    .wr_idx  (beat_cnt),
    .wr_data (in_data),
    .rd_a    (a1),
    .rd_b    (b1)
  );

  assign A = rd_bank ? a1 : a0;
  assign B = rd_bank ? b1 : b0;

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader with W=2.
module tb_matrix_loader;

  localparam int W = 2;
  typedef logic [0:8][W-1:0] mat_t;

  typedef struct {
    mat_t a;
    mat_t b;
    int   hold;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         flush;
  mat_t         A, B;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   pair_count;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_pc;

  always #5 clk = ~clk;

  matrix_loader #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .A          (A),
    .B          (B),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pair_count (pair_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [W-1:0] d);
    int budget;
    budget   = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && budget < 300) begin
      step();
      budget++;
    end
    if (!in_ready) timeout("send_beat");
    else step();
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input mat_t a, input mat_t b);
    for (int k = 0; k < 9; k++) send_beat(a[k]);
    for (int k = 0; k < 9; k++) send_beat(b[k]);
  endtask

  task automatic recv(input string name, input mat_t ea, input mat_t eb);
    int budget;
    budget    = 0;
    out_ready = 1'b1;
    while (!out_valid && budget < 300) begin
      step();
      budget++;
    end
    if (!out_valid) begin
      timeout(name);
    end else begin
      chk({name, "_A"}, A, ea);
      chk({name, "_B"}, B, eb);
      step();
      exp_pc = exp_pc + 8'd1;
    end
  endtask

  function automatic mat_t pattern(input int seed);
    mat_t m;
    for (int e = 0; e < 9; e++) m[e] = 2'(seed + e);
    return m;
  endfunction

  vec_t vecs [4];
  mat_t f1a, f1b, f2a, f2b, f3a, f3b, ones, ya, yb;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{a: {2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0},
                b: {2'd3,2'd3,2'd3,2'd3,2'd3,2'd3,2'd3,2'd3,2'd3}, hold: 0};
    vecs[1] = '{a: {2'd1,2'd2,2'd1,2'd2,2'd1,2'd2,2'd1,2'd2,2'd1},
                b: {2'd2,2'd1,2'd2,2'd1,2'd2,2'd1,2'd2,2'd1,2'd2}, hold: 3};
    vecs[2] = '{a: {2'd3,2'd2,2'd1,2'd0,2'd3,2'd2,2'd1,2'd0,2'd3},
                b: {2'd0,2'd0,2'd1,2'd1,2'd2,2'd2,2'd3,2'd3,2'd0}, hold: 1};
    vecs[3] = '{a: {2'd3,2'd0,2'd0,2'd0,2'd3,2'd0,2'd0,2'd0,2'd3},
                b: {2'd1,2'd1,2'd1,2'd0,2'd0,2'd0,2'd2,2'd2,2'd2}, hold: 5};
    f1a  = {2'd1,2'd1,2'd1,2'd1,2'd1,2'd1,2'd1,2'd1,2'd2};
    f1b  = {2'd0,2'd1,2'd0,2'd1,2'd0,2'd1,2'd0,2'd1,2'd0};
    f2a  = {2'd2,2'd2,2'd2,2'd3,2'd3,2'd3,2'd0,2'd0,2'd0};
    f2b  = {2'd3,2'd0,2'd3,2'd0,2'd3,2'd0,2'd3,2'd0,2'd3};
    f3a  = {2'd0,2'd3,2'd2,2'd1,2'd0,2'd3,2'd2,2'd1,2'd0};
    f3b  = {2'd2,2'd2,2'd0,2'd0,2'd1,2'd1,2'd3,2'd3,2'd2};
    ones = {2'd1,2'd1,2'd1,2'd1,2'd1,2'd1,2'd1,2'd1,2'd1};
    ya   = {2'd2,2'd3,2'd0,2'd1,2'd2,2'd3,2'd0,2'd1,2'd2};
    yb   = {2'd1,2'd3,2'd1,2'd3,2'd1,2'd3,2'd1,2'd3,2'd1};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    exp_pc = 8'd0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_pair_count", pair_count, 0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // first frame, latency of one cycle after the 18th beat
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) send_beat(2'(k));
    for (int k = 0; k < 8; k++) send_beat(2'd3);
    chk("lat_before_last", out_valid, 0);
    send_beat(2'd3);
    chk("lat_out_valid", out_valid, 1);
    chk("first_A", A, {2'd0,2'd1,2'd2,2'd3,2'd0,2'd1,2'd2,2'd3,2'd0});
    chk("first_B", B, {2'd3,2'd3,2'd3,2'd3,2'd3,2'd3,2'd3,2'd3,2'd3});
    step();
    exp_pc = 8'd1;
    chk("first_pair_count", pair_count, 1);
    chk("first_consumed", out_valid, 0);

    // table of frames, each held a number of cycles before consumption
    for (int v = 0; v < 4; v++) begin
      out_ready = 1'b0;
      send_frame(vecs[v].a, vecs[v].b);
      for (int h = 0; h < vecs[v].hold; h++) begin
        step();
        chk("vec_hold_valid", out_valid, 1);
      end
      recv("vec", vecs[v].a, vecs[v].b);
      chk("vec_pair_count", pair_count, exp_pc);
    end

    // two frames fill both banks, third is back-pressured
    out_ready = 1'b0;
    send_frame(f1a, f1b);
    send_frame(f2a, f2b);
    chk("both_full_in_ready", in_ready, 0);
    chk("both_full_A", A, f1a);
    fork
      send_frame(f3a, f3b);
      begin
        repeat (3) step();
        chk("stall_in_ready", in_ready, 0);
        recv("order1", f1a, f1b);
        recv("order2", f2a, f2b);
        recv("order3", f3a, f3b);
      end
    join
    chk("drain_in_ready", in_ready, 1);
    chk("drain_out_valid", out_valid, 0);
    chk("drain_pair_count", pair_count, exp_pc);

    // output stalled for 10 cycles while the next frame streams in
    out_ready = 1'b0;
    send_frame(vecs[2].a, vecs[2].b);
    fork
      send_frame(vecs[1].a, vecs[1].b);
      for (int h = 0; h < 10; h++) begin
        step();
        chk("stable_A", A, vecs[2].a);
        chk("stable_B", B, vecs[2].b);
      end
    join
    chk("stall_full_in_ready", in_ready, 0);
    recv("stall_first", vecs[2].a, vecs[2].b);
    recv("stall_second", vecs[1].a, vecs[1].b);

    // flush after 7 beats, flushed-cycle data ignored
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) send_beat(2'd2);
    flush = 1'b1; in_valid = 1'b1; in_data = 2'd0;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_in_ready", in_ready, 1);
    chk("flush_out_valid", out_valid, 0);
    send_frame(ones, ones);
    recv("flush_frame", ones, ones);
    chk("flush_pair_count", pair_count, exp_pc);

    // asynchronous reset mid-frame
    for (int k = 0; k < 12; k++) send_beat(2'd3);
    chk("partial_A", A, {2'd3,2'd3,2'd3,2'd3,2'd3,2'd3,2'd3,2'd3,2'd3});
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_in_ready", in_ready, 1);
    chk("async_out_valid", out_valid, 0);
    chk("async_A", A, 0);
    chk("async_B", B, 0);
    chk("async_pair_count", pair_count, 0);
    exp_pc = 8'd0;
    @(negedge clk) rst_n = 1'b1;
    step();
    send_frame(f3a, f3b);
    recv("post_reset", f3a, f3b);
    chk("post_reset_pc", pair_count, exp_pc);

    // 255 more frames wrap pair_count to 0
    out_ready = 1'b1;
    for (int f = 0; f < 255; f++) send_frame(pattern(f), pattern(f + 1));
    step();
    step();
    exp_pc = exp_pc + 8'd255;
    chk("wrap_pair_count", pair_count, exp_pc);
    chk("wrap_is_zero", pair_count, 0);

    // handshake coincides with the 18th beat of the next frame
    out_ready = 1'b0;
    send_frame(f2a, f2b);
    for (int k = 0; k < 9; k++) send_beat(ya[k]);
    for (int k = 0; k < 8; k++) send_beat(yb[k]);
    out_ready = 1'b1;
    send_beat(yb[8]);
    exp_pc = exp_pc + 8'd1;
    chk("coinc_out_valid", out_valid, 1);
    chk("coinc_A", A, ya);
    chk("coinc_B", B, yb);
    chk("coinc_pair_count", pair_count, exp_pc);
    step();
    exp_pc = exp_pc + 8'd1;
    chk("coinc_drain_pc", pair_count, exp_pc);
    chk("coinc_drain_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
